// File: rtl/poly_voice_ctrl_pkg.sv
// Shared types and helpers for the polyphonic voice controller.
// Voice state encodings match the tone-generator family (IDLE=0, TIMED=1, GATED=2).
package poly_voice_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TIMED = 2'd1,
        ST_GATED = 2'd2
    } voice_state_e;

    localparam int DEF_FREQ_W = 8;
    localparam int DEF_LEN_W  = 8;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/poly_voice_ctrl_voice_slot.sv
// One tone voice: holds its half-period, remaining tick count and owning key.
// A load always overrides expiry/release so a stolen or retriggered voice never goes silent.
module voice_slot
    import poly_voice_ctrl_pkg::*;
#(
    parameter int FREQ_W = DEF_FREQ_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int KW     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [FREQ_W-1:0] i_hp,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [KW-1:0]     i_key,
    input  logic              i_tick,
    input  logic              i_release,
    output logic [FREQ_W-1:0] o_freq,
    output logic              o_active,
    output logic [KW-1:0]     o_key,
    output logic [LEN_W-1:0]  o_cost
);

    voice_state_e      r_state, w_state_nx;
    logic [FREQ_W-1:0] r_hp, w_hp_nx;
    logic [LEN_W-1:0]  r_rem, w_rem_nx;
    logic [KW-1:0]     r_key, w_key_nx;

    // Voice state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_hp    <= '0;
            r_rem   <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_hp    <= w_hp_nx;
            r_rem   <= w_rem_nx;
            r_key   <= w_key_nx;
        end
    end

    // Next-state: load, tick countdown, gate release
    always_comb begin
        w_state_nx = r_state;
        w_hp_nx    = r_hp;
        w_rem_nx   = r_rem;
        w_key_nx   = r_key;
        if (i_load) begin
            w_hp_nx    = i_hp;
            w_key_nx   = i_key;
            w_rem_nx   = i_len;
            w_state_nx = (i_len != '0) ? ST_TIMED : ST_GATED;
        end else begin
            case (r_state)
                ST_TIMED: begin
                    if (i_tick && (r_rem == LEN_W'(1))) begin
                        w_state_nx = ST_IDLE;
                        w_hp_nx    = '0;
                        w_rem_nx   = '0;
                    end else if (i_tick) begin
                        w_rem_nx = r_rem - LEN_W'(1);
                    end else begin
                        w_rem_nx = r_rem;
                    end
                end
                ST_GATED: begin
                    if (i_release) begin
                        w_state_nx = ST_IDLE;
                        w_hp_nx    = '0;
                    end else begin
                        w_state_nx = ST_GATED;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_hp_nx    = '0;
                    w_rem_nx   = '0;
                end
            endcase
        end
    end

    assign o_freq   = r_hp;
    assign o_active = (r_state != ST_IDLE);
    assign o_key    = r_key;
    // Gated notes have no countdown, so they are the last choice when stealing
    assign o_cost   = (r_state == ST_GATED) ? {LEN_W{1'b1}} : r_rem;

endmodule

// File: rtl/poly_voice_ctrl.sv
// Polyphonic voice controller: key synchronisers, note table, tick prescaler
// and a one-key-per-cycle allocator driving NUM_VOICES voice_slot instances.
module poly_voice_ctrl
    import poly_voice_ctrl_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NUM_KEYS   = 4,
    parameter int FREQ_W     = DEF_FREQ_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int TICK_DIV   = 256,
    parameter int STEAL      = 1,
    localparam int KW        = clog2_min1(NUM_KEYS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_KEYS-1:0]          key,
    input  logic                         cfg_we,
    input  logic [KW-1:0]                cfg_addr,
    input  logic [FREQ_W-1:0]            cfg_half_period,
    input  logic [LEN_W-1:0]             cfg_len,
    output logic [NUM_VOICES*FREQ_W-1:0] freq,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*KW-1:0]     voice_key,
    output logic                         drop_pulse
);

    localparam int VW = clog2_min1(NUM_VOICES);
    localparam int PW = clog2_min1(TICK_DIV);

    logic [NUM_KEYS-1:0] r_sync1, r_sync2, r_sync3, r_pending;
    logic [PW-1:0]       r_presc;
    logic                r_drop;
    logic [FREQ_W-1:0]   r_tab_hp  [NUM_KEYS];
    logic [LEN_W-1:0]    r_tab_len [NUM_KEYS];

    logic [NUM_KEYS-1:0]   w_rise, w_clear;
    logic                  w_tick, w_any, w_alloc, w_drop;
    logic [KW-1:0]         w_sel_key;
    logic [FREQ_W-1:0]     w_sel_hp;
    logic [LEN_W-1:0]      w_sel_len, w_best;
    logic                  w_rt_hit, w_free_hit;
    logic [VW-1:0]         w_rt_idx, w_free_idx, w_steal_idx, w_target;
    logic [NUM_VOICES-1:0] w_load, w_release;
    logic [KW-1:0]         w_vkey [NUM_VOICES];
    logic [LEN_W-1:0]      w_cost [NUM_VOICES];

    assign w_rise     = r_sync2 & ~r_sync3;
    assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
    assign w_sel_hp   = r_tab_hp[w_sel_key];
    assign w_sel_len  = r_tab_len[w_sel_key];
    assign drop_pulse = r_drop;

    // Synchronisers, pending flags, drop pulse and tick prescaler
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync3   <= '0;
            r_pending <= '0;
            r_drop    <= 1'b0;
            r_presc   <= '0;
        end else begin
            r_sync1   <= key;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_pending <= (r_pending & ~w_clear) | w_rise;
            r_drop    <= w_drop;
            r_presc   <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    // Note table; out-of-range addresses are ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_tab_hp[k]  <= '0;
                r_tab_len[k] <= '0;
            end
        end else if (cfg_we && ({1'b0, cfg_addr} < (KW+1)'(NUM_KEYS))) begin
            r_tab_hp[cfg_addr]  <= cfg_half_period;
            r_tab_len[cfg_addr] <= cfg_len;
        end
    end

    // Candidate search: lowest pending key, retrigger owner, lowest free voice, steal victim
    always_comb begin
        w_any       = 1'b0;
        w_sel_key   = '0;
        w_clear     = '0;
        w_rt_hit    = 1'b0;
        w_rt_idx    = '0;
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        w_steal_idx = '0;
        w_best      = w_cost[0];
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            w_sel_key = r_pending[k] ? KW'(k) : w_sel_key;
            w_any     = w_any | r_pending[k];
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            w_clear[k] = w_any && (w_sel_key == KW'(k));
        end
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            w_rt_idx   = (voice_active[v] && (w_vkey[v] == w_sel_key)) ? VW'(v) : w_rt_idx;
            w_rt_hit   = w_rt_hit | (voice_active[v] && (w_vkey[v] == w_sel_key));
            w_free_idx = !voice_active[v] ? VW'(v) : w_free_idx;
            w_free_hit = w_free_hit | !voice_active[v];
        end
        for (int v = 1; v < NUM_VOICES; v++) begin
            w_steal_idx = (w_cost[v] < w_best) ? VW'(v) : w_steal_idx;
            w_best      = (w_cost[v] < w_best) ? w_cost[v] : w_best;
        end
    end

    // Allocation decision for the served key (silent entries are consumed without effect)
    always_comb begin
        w_alloc  = 1'b0;
        w_drop   = 1'b0;
        w_target = '0;
        if (w_any && (w_sel_hp != '0)) begin
            if (w_rt_hit) begin
                w_alloc  = 1'b1;
                w_target = w_rt_idx;
            end else if (w_free_hit) begin
                w_alloc  = 1'b1;
                w_target = w_free_idx;
            end else if (STEAL != 0) begin
                w_alloc  = 1'b1;
                w_target = w_steal_idx;
            end else begin
                w_drop = 1'b1;
            end
        end else begin
            w_alloc = 1'b0;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign w_load[v]    = w_alloc && (w_target == VW'(v));
        assign w_release[v] = ~r_sync3[w_vkey[v]];
        assign voice_key[v*KW +: KW] = w_vkey[v];

        voice_slot #(
            .FREQ_W (FREQ_W),
            .LEN_W  (LEN_W),
            .KW     (KW)
        ) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_load    (w_load[v]),
            .i_hp      (w_sel_hp),
            .i_len     (w_sel_len),
            .i_key     (w_sel_key),
            .i_tick    (w_tick),
            .i_release (w_release[v]),
            .o_freq    (freq[v*FREQ_W +: FREQ_W]),
            .o_active  (voice_active[v]),
            .o_key     (w_vkey[v]),
            .o_cost    (w_cost[v])
        );
    end

endmodule

// File: tb/tb_poly_voice_ctrl.sv
// Bench for poly_voice_ctrl: three configurations share one stimulus stream and are
// compared every cycle against a note-level reference model, plus directed scenario checks.
module tb_poly_voice_ctrl;

    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  key;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_hp, cfg_len;

    logic [31:0] freq_a;
    logic [3:0]  act_a;
    logic [7:0]  vkey_a;
    logic        drop_a;
    logic [15:0] freq_b, freq_c;
    logic [1:0]  act_b, act_c;
    logic [3:0]  vkey_b, vkey_c;
    logic        drop_b, drop_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    poly_voice_ctrl #(.NUM_VOICES(4), .NUM_KEYS(4), .TICK_DIV(TDIV), .STEAL(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .key(key), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_half_period(cfg_hp), .cfg_len(cfg_len), .freq(freq_a), .voice_active(act_a),
        .voice_key(vkey_a), .drop_pulse(drop_a));

    poly_voice_ctrl #(.NUM_VOICES(2), .NUM_KEYS(4), .TICK_DIV(TDIV), .STEAL(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .key(key), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_half_period(cfg_hp), .cfg_len(cfg_len), .freq(freq_b), .voice_active(act_b),
        .voice_key(vkey_b), .drop_pulse(drop_b));

    poly_voice_ctrl #(.NUM_VOICES(2), .NUM_KEYS(3), .TICK_DIV(TDIV), .STEAL(0)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .key(key[2:0]), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_half_period(cfg_hp), .cfg_len(cfg_len), .freq(freq_c), .voice_active(act_c),
        .voice_key(vkey_c), .drop_pulse(drop_c));

    // Reference model state, one row per configuration
    int nv [3] = '{4, 2, 2};
    int nk [3] = '{4, 4, 3};
    int st [3] = '{1, 1, 0};
    int m_pend [3][4];
    int m_act  [3][4];
    int m_gate [3][4];
    int m_hp   [3][4];
    int m_rem  [3][4];
    int m_vkey [3][4];
    int m_thp  [3][4];
    int m_tlen [3][4];
    int m_presc [3];
    int m_drop  [3];
    logic [3:0] m_seen [3][3];   // key levels as seen 1, 2 and 3 clocks ago

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic mreset(input int i);
        for (int j = 0; j < 4; j++) begin
            m_pend[i][j] = 0; m_act[i][j] = 0; m_gate[i][j] = 0; m_hp[i][j] = 0;
            m_rem[i][j] = 0; m_vkey[i][j] = 0; m_thp[i][j] = 0; m_tlen[i][j] = 0;
        end
        m_presc[i] = 0;
        m_drop[i]  = 0;
        for (int d = 0; d < 3; d++) m_seen[i][d] = 4'h0;
    endtask

    function automatic int cost(input int i, input int v);
        return m_gate[i][v] ? 255 : m_rem[i][v];
    endfunction

    // One clock of the note-level model using the inputs held across the edge
    task automatic mstep(input int i);
        int served, tgt, best;
        logic tick;
        logic [3:0] rise, mask;
        mask   = (nk[i] == 4) ? 4'hF : 4'h7;
        tick   = (m_presc[i] == TDIV - 1);
        rise   = m_seen[i][1] & ~m_seen[i][2];
        served = -1;
        for (int k = 0; k < nk[i]; k++) if (m_pend[i][k] != 0 && served < 0) served = k;
        tgt = -1;
        m_drop[i] = 0;
        if (served >= 0 && m_thp[i][served] != 0) begin
            for (int v = 0; v < nv[i]; v++)
                if (m_act[i][v] != 0 && m_vkey[i][v] == served && tgt < 0) tgt = v;
            for (int v = 0; v < nv[i]; v++)
                if (m_act[i][v] == 0 && tgt < 0) tgt = v;
            if (tgt < 0 && st[i] != 0) begin
                best = 0;
                for (int v = 1; v < nv[i]; v++) if (cost(i, v) < cost(i, best)) best = v;
                tgt = best;
            end
            if (tgt < 0) m_drop[i] = 1;
        end
        for (int v = 0; v < nv[i]; v++) begin
            if (v == tgt) begin
                m_act[i][v]  = 1;
                m_hp[i][v]   = m_thp[i][served];
                m_vkey[i][v] = served;
                m_rem[i][v]  = m_tlen[i][served];
                m_gate[i][v] = (m_tlen[i][served] == 0);
            end else if (m_act[i][v] != 0 && m_gate[i][v] != 0) begin
                if (!m_seen[i][2][m_vkey[i][v]]) m_act[i][v] = 0;
            end else if (m_act[i][v] != 0 && tick) begin
                if (m_rem[i][v] == 1) m_act[i][v] = 0;
                else m_rem[i][v] = m_rem[i][v] - 1;
            end
        end
        if (served >= 0) m_pend[i][served] = 0;
        for (int k = 0; k < nk[i]; k++) if (rise[k]) m_pend[i][k] = 1;
        if (cfg_we && int'(cfg_addr) < nk[i]) begin
            m_thp[i][cfg_addr]  = cfg_hp;
            m_tlen[i][cfg_addr] = cfg_len;
        end
        m_presc[i]   = (m_presc[i] + 1) % TDIV;
        m_seen[i][2] = m_seen[i][1];
        m_seen[i][1] = m_seen[i][0];
        m_seen[i][0] = key & mask;
    endtask

    task automatic compare_all();
        logic [31:0] ef [3];
        logic [31:0] ea [3];
        logic [31:0] ek [3];
        for (int i = 0; i < 3; i++) begin
            ef[i] = '0; ea[i] = '0; ek[i] = '0;
            for (int v = 0; v < nv[i]; v++) begin
                ef[i][v*8 +: 8] = (m_act[i][v] != 0) ? 8'(m_hp[i][v]) : 8'h00;
                ea[i][v]        = (m_act[i][v] != 0);
                ek[i][v*2 +: 2] = 2'(m_vkey[i][v]);
            end
        end
        check_eq("freq_a", freq_a, ef[0]);
        check_eq("act_a", {28'h0, act_a}, ea[0]);
        check_eq("vkey_a", {24'h0, vkey_a}, ek[0]);
        check_eq("drop_a", {31'h0, drop_a}, 32'(m_drop[0]));
        check_eq("freq_b", {16'h0, freq_b}, ef[1]);
        check_eq("act_b", {30'h0, act_b}, ea[1]);
        check_eq("vkey_b", {28'h0, vkey_b}, ek[1]);
        check_eq("drop_b", {31'h0, drop_b}, 32'(m_drop[1]));
        check_eq("freq_c", {16'h0, freq_c}, ef[2]);
        check_eq("act_c", {30'h0, act_c}, ea[2]);
        check_eq("vkey_c", {28'h0, vkey_c}, ek[2]);
        check_eq("drop_c", {31'h0, drop_c}, 32'(m_drop[2]));
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (reset_n) mstep(i);
            else mreset(i);
        end
        #1;
        compare_all();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] hp, input logic [7:0] len);
        cfg_we = 1'b1; cfg_addr = a; cfg_hp = hp; cfg_len = len;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; key = 4'h0; cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) mreset(i);
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        int on, off, drops;
        reset_n = 1'b0; key = 4'h0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_hp = 8'd0; cfg_len = 8'd0;
        for (int i = 0; i < 3; i++) mreset(i);
        do_reset();

        // Timed note: latency 4 clocks, length 3 ticks of 4 clocks
        cfg_write(2'd0, 8'd4, 8'd3);
        cfg_write(2'd1, 8'd40, 8'd0);
        key[0] = 1'b1;
        on = -1; off = -1;
        for (int n = 1; n <= 30; n++) begin
            cycle();
            if (freq_a[7:0] == 8'd4 && on < 0) on = n;
            if (on >= 0 && off < 0 && freq_a[7:0] == 8'd0) off = n;
        end
        check_eq("timed_latency", 32'(on), 32'd4);
        check_eq("timed_length_in_9_12", {31'h0, (off - on >= 9) && (off - on <= 12)}, 32'd1);
        key[0] = 1'b0;
        for (int n = 0; n < 5; n++) cycle();

        // Gate mode: held for 50 clocks, silent 4 clocks after release
        key[1] = 1'b1;
        for (int n = 0; n < 50; n++) cycle();
        check_eq("gate_held", {24'h0, freq_a[7:0]}, 32'd40);
        key[1] = 1'b0;
        off = -1;
        for (int n = 1; n <= 20; n++) begin
            cycle();
            if (off < 0 && freq_a[7:0] == 8'd0) off = n;
        end
        check_eq("gate_release_delay", 32'(off), 32'd4);

        // Four keys rising together are served one per clock
        do_reset();
        for (int k = 0; k < 4; k++) cfg_write(2'(k), 8'(10 + k), 8'd200);
        key = 4'hF;
        for (int n = 1; n <= 7; n++) begin
            cycle();
            if (n == 4) check_eq("simul_first", freq_a, 32'h0000_000a);
        end
        check_eq("simul_all", freq_a, 32'h0d0c_0b0a);
        key = 4'h0;
        for (int n = 0; n < 6; n++) cycle();

        // Steal (configuration B) and drop (configuration C)
        do_reset();
        cfg_write(2'd0, 8'd50, 8'd200);
        cfg_write(2'd1, 8'd60, 8'd20);
        cfg_write(2'd2, 8'd70, 8'd5);
        key = 4'b0001;
        for (int n = 0; n < 6; n++) cycle();
        key = 4'b0011;
        for (int n = 0; n < 10; n++) cycle();
        key = 4'b0111;
        drops = 0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (drop_c) drops++;
        end
        check_eq("steal_hp", {24'h0, freq_b[15:8]}, 32'd70);
        check_eq("steal_key", {30'h0, vkey_b[3:2]}, 32'd2);
        check_eq("drop_count", 32'(drops), 32'd1);
        check_eq("drop_voices_kept", {16'h0, freq_c}, 32'h0000_3c32);

        // Retrigger keeps the same voice
        key = 4'h0;
        for (int n = 0; n < 5; n++) cycle();
        key[0] = 1'b1;
        for (int n = 0; n < 6; n++) cycle();
        check_eq("retrig_key", {30'h0, vkey_a[1:0]}, 32'd0);
        check_eq("retrig_hp", {24'h0, freq_a[7:0]}, 32'd50);
        check_eq("retrig_no_new_voice", {31'h0, act_a[3]}, 32'd0);

        // Asynchronous reset between edges silences everything at once
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("async_freq", freq_a, 32'h0);
        check_eq("async_active", {28'h0, act_a}, 32'h0);
        for (int i = 0; i < 3; i++) mreset(i);
        key = 4'h0;
        cycle();
        cycle();
        reset_n = 1'b1;

        // Randomised traffic against the model
        for (int k = 0; k < 4; k++) cfg_write(2'(k), 8'($urandom_range(1, 255)), 8'($urandom_range(0, 6)));
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_hp   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            cfg_len  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 11) == 0) key[k] = ~key[k];
            cycle();
        end
        cfg_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
